// File: rtl/neopixel_frame_ctrl.sv
// NeoPixel frame controller: a double-buffered RGB frame store filled from a UART byte stream,
// streamed one pixel at a time to a single-pixel serialiser at a programmable refresh rate.
module neopixel_frame_ctrl #(
    parameter int NUM_PIXELS     = 10,
    parameter int REFRESH_CYCLES = 1048576,
    parameter int RX_TIMEOUT     = 120000,
    parameter int BRIGHT_SHIFT   = 0
) (
    input  logic       CLK,
    input  logic       RESETN,
    input  logic [7:0] rx_byte,
    input  logic       rx_valid,
    input  logic       px_busy,
    output logic       px_valid,
    output logic [7:0] px_r,
    output logic [7:0] px_g,
    output logic [7:0] px_b,
    output logic       frame_done,
    output logic       swap_pend
);

    localparam int IDX_W = (NUM_PIXELS > 1) ? $clog2(NUM_PIXELS) : 1;
    localparam int REF_W = $clog2(REFRESH_CYCLES);
    localparam int TO_W  = (RX_TIMEOUT > 1) ? $clog2(RX_TIMEOUT) : 1;

    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_PIXELS - 1);
    localparam logic [REF_W-1:0] REF_LAST = REF_W'(REFRESH_CYCLES - 1);
    localparam logic [TO_W-1:0]  TO_LAST  = TO_W'(RX_TIMEOUT - 1);

    typedef enum logic [1:0] {GAP, LOAD, ACK, DRAIN} state_t;

    state_t           state;
    state_t           state_next;

    logic [7:0]       frame_mem [0:1][0:NUM_PIXELS-1][0:2];
    logic             front_sel;
    logic [IDX_W-1:0] wr_ptr;
    logic [1:0]       byte_idx;
    logic [TO_W-1:0]  to_cnt;
    logic [REF_W-1:0] ref_cnt;
    logic [IDX_W-1:0] px_idx;

    logic             swap_now;
    logic             wr_en;
    logic             wr_sel;
    logic             last_byte;
    logic             in_gap;
    logic             load_px;
    logic             ack_done;
    logic             next_px;
    logic             frame_end;

    // The swap cycle hands the old front to the loader, so a byte arriving then lands at wr_ptr=0.
    assign swap_now  = (state == GAP) && (ref_cnt == REF_LAST) && swap_pend;
    assign wr_en     = rx_valid && (!swap_pend || swap_now);
    assign wr_sel    = swap_now ? front_sel : ~front_sel;
    assign last_byte = (wr_ptr == LAST_IDX) && (byte_idx == 2'd2);

    // NOTE: the frame store has no reset; clearing an array costs a write port per entry, and the
    // loader pointers alone decide which bytes are meaningful.
    always_ff @(posedge CLK) begin
        if (wr_en) begin
            frame_mem[wr_sel][wr_ptr][byte_idx] <= rx_byte;
        end
    end

    // NOTE: every clocked process uses non-blocking assignments so all registers update from
    // the same pre-edge values regardless of evaluation order.
    always_ff @(posedge CLK) begin
        if (!RESETN) begin
            wr_ptr    <= '0;
            byte_idx  <= '0;
            to_cnt    <= '0;
            swap_pend <= 1'b0;
            front_sel <= 1'b0;
        end else begin
            if (swap_now) begin
                front_sel <= ~front_sel;
                swap_pend <= 1'b0;
            end
            if (rx_valid) begin
                to_cnt <= '0;
                if (wr_en) begin
                    if (byte_idx == 2'd2) begin
                        byte_idx <= '0;
                        if (last_byte) begin
                            wr_ptr    <= '0;
                            swap_pend <= 1'b1;
                        end else begin
                            wr_ptr <= wr_ptr + 1'b1;
                        end
                    end else begin
                        byte_idx <= byte_idx + 2'd1;
                    end
                end
            end else if ((wr_ptr != '0) || (byte_idx != '0)) begin
                // A stalled partial frame is abandoned so the next byte starts a fresh frame.
                if (to_cnt == TO_LAST) begin
                    wr_ptr   <= '0;
                    byte_idx <= '0;
                    to_cnt   <= '0;
                end else begin
                    to_cnt <= to_cnt + 1'b1;
                end
            end else begin
                to_cnt <= '0;
            end
        end
    end

    always_ff @(posedge CLK) begin
        if (!RESETN) begin
            state <= GAP;
        end else begin
            state <= state_next;
        end
    end

    // NOTE: combinational blocks assign a default first so no path leaves a signal unassigned,
    // which would otherwise infer a latch.
    always_comb begin
        state_next = state;
        case (state)
            GAP:     if (ref_cnt == REF_LAST) state_next = LOAD;
            LOAD:    state_next = ACK;
            ACK:     if (px_busy) state_next = DRAIN;
            DRAIN:   if (!px_busy) state_next = (px_idx == LAST_IDX) ? GAP : LOAD;
            default: state_next = GAP;
        endcase
    end

    always_comb begin
        in_gap    = (state == GAP);
        load_px   = (state == LOAD);
        ack_done  = (state == ACK) && px_busy;
        next_px   = (state == DRAIN) && !px_busy && (px_idx != LAST_IDX);
        frame_end = (state == DRAIN) && !px_busy && (px_idx == LAST_IDX);
    end

    always_ff @(posedge CLK) begin
        if (!RESETN) begin
            ref_cnt    <= '0;
            px_idx     <= '0;
            px_valid   <= 1'b0;
            px_r       <= '0;
            px_g       <= '0;
            px_b       <= '0;
            frame_done <= 1'b0;
        end else begin
            frame_done <= frame_end;
            if (frame_end || (in_gap && ref_cnt == REF_LAST)) begin
                ref_cnt <= '0;
            end else if (in_gap) begin
                ref_cnt <= ref_cnt + 1'b1;
            end
            if (in_gap) begin
                px_idx <= '0;
            end else if (next_px) begin
                px_idx <= px_idx + 1'b1;
            end
            if (load_px) begin
                px_r     <= frame_mem[front_sel][px_idx][0] >> BRIGHT_SHIFT;
                px_g     <= frame_mem[front_sel][px_idx][1] >> BRIGHT_SHIFT;
                px_b     <= frame_mem[front_sel][px_idx][2] >> BRIGHT_SHIFT;
                px_valid <= 1'b1;
            end else if (ack_done) begin
                px_valid <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_neopixel_frame_ctrl.sv
// Directed bench for neopixel_frame_ctrl: a 3-pixel instance for loading, timeout, drop, reset
// and stall scenarios, and a 2-pixel instance with a brightness shift of 2.
module tb_neopixel_frame_ctrl;

    logic       clk = 1'b0;
    always #5 clk = ~clk;

    logic       resetn, rx_valid, px_busy, px_valid, frame_done, swap_pend;
    logic [7:0] rx_byte, px_r, px_g, px_b;
    logic       resetn2, rx_valid2, px_busy2, px_valid2, frame_done2, swap_pend2;
    logic [7:0] rx_byte2, px_r2, px_g2, px_b2;

    int checks = 0;
    int errors = 0;

    neopixel_frame_ctrl #(
        .NUM_PIXELS(3), .REFRESH_CYCLES(16), .RX_TIMEOUT(40), .BRIGHT_SHIFT(0)
    ) dut (
        .CLK(clk), .RESETN(resetn), .rx_byte(rx_byte), .rx_valid(rx_valid),
        .px_busy(px_busy), .px_valid(px_valid), .px_r(px_r), .px_g(px_g), .px_b(px_b),
        .frame_done(frame_done), .swap_pend(swap_pend)
    );

    neopixel_frame_ctrl #(
        .NUM_PIXELS(2), .REFRESH_CYCLES(16), .RX_TIMEOUT(40), .BRIGHT_SHIFT(2)
    ) dut_dim (
        .CLK(clk), .RESETN(resetn2), .rx_byte(rx_byte2), .rx_valid(rx_valid2),
        .px_busy(px_busy2), .px_valid(px_valid2), .px_r(px_r2), .px_g(px_g2), .px_b(px_b2),
        .frame_done(frame_done2), .swap_pend(swap_pend2)
    );

    // Serialiser models: accept a pixel, stay busy 4 cycles, log the accepted pixel.
    int          busy_cnt = 0, busy_cnt2 = 0;
    bit          busy_hold = 1'b0;
    int          fd_high = 0, fd_high2 = 0;
    logic [23:0] capq[$];
    logic [23:0] capq2[$];

    initial begin
        px_busy = 1'b0;
        forever begin
            @(posedge clk); #1;
            if (frame_done === 1'b1) fd_high++;
            if (busy_cnt > 0) begin
                busy_cnt--;
                if (busy_cnt == 0) px_busy = 1'b0;
            end else if (px_valid === 1'b1 && !busy_hold) begin
                px_busy  = 1'b1;
                busy_cnt = 4;
                capq.push_back({px_r, px_g, px_b});
            end
        end
    end

    initial begin
        px_busy2 = 1'b0;
        forever begin
            @(posedge clk); #1;
            if (frame_done2 === 1'b1) fd_high2++;
            if (busy_cnt2 > 0) begin
                busy_cnt2--;
                if (busy_cnt2 == 0) px_busy2 = 1'b0;
            end else if (px_valid2 === 1'b1) begin
                px_busy2  = 1'b1;
                busy_cnt2 = 4;
                capq2.push_back({px_r2, px_g2, px_b2});
            end
        end
    end

    task automatic send_byte(input int which, input logic [7:0] b);
        if (which == 1) begin rx_byte = b; rx_valid = 1'b1; end
        else begin rx_byte2 = b; rx_valid2 = 1'b1; end
        @(posedge clk); #1;
        rx_valid  = 1'b0;
        rx_valid2 = 1'b0;
    endtask

    task automatic wait_swap(input int which, output bit ok);
        ok = 1'b0;
        for (int i = 0; i < 300; i++) begin
            @(negedge clk);
            if ((which == 1 ? swap_pend : swap_pend2) === 1'b0) begin ok = 1'b1; break; end
        end
    endtask

    task automatic wait_fd(input int which, output bit ok);
        ok = 1'b0;
        for (int i = 0; i < 300; i++) begin
            @(negedge clk);
            if ((which == 1 ? fd_high : fd_high2) > 0) begin ok = 1'b1; break; end
        end
    endtask

    task automatic wait_valid(output bit ok);
        ok = 1'b0;
        for (int i = 0; i < 300; i++) begin
            @(negedge clk);
            if (px_valid === 1'b1) begin ok = 1'b1; break; end
        end
    endtask

    task automatic test_reset();
        resetn = 1'b0; resetn2 = 1'b0; rx_valid = 1'b0; rx_valid2 = 1'b0;
        rx_byte = 8'h00; rx_byte2 = 8'h00;
        repeat (3) @(posedge clk);
        #1;
        checks++; if (px_valid !== 1'b0) begin errors++; $display("FAIL reset_px_valid: got %b want 0", px_valid); end
        checks++; if ({px_r, px_g, px_b} !== 24'h0) begin errors++; $display("FAIL reset_rgb: got %h want 000000", {px_r, px_g, px_b}); end
        checks++; if (frame_done !== 1'b0) begin errors++; $display("FAIL reset_frame_done: got %b want 0", frame_done); end
        checks++; if (swap_pend !== 1'b0) begin errors++; $display("FAIL reset_swap_pend: got %b want 0", swap_pend); end
        checks++; if (px_valid2 !== 1'b0 || swap_pend2 !== 1'b0) begin errors++; $display("FAIL reset_dim: got valid=%b pend=%b want 0 0", px_valid2, swap_pend2); end
        resetn = 1'b1; resetn2 = 1'b1;
    endtask

    task automatic test_frame();
        bit          ok;
        logic [23:0] got;
        logic [23:0] exp_px [3];
        exp_px = '{24'h010203, 24'h040506, 24'h070809};
        for (int i = 1; i <= 9; i++) send_byte(1, 8'(i));
        checks++; if (swap_pend !== 1'b1) begin errors++; $display("FAIL frame_pend_set: got %b want 1", swap_pend); end
        wait_swap(1, ok);
        checks++; if (!ok) begin errors++; $display("FAIL frame_swap_timeout: got no swap want swap"); end
        capq.delete(); fd_high = 0;
        wait_fd(1, ok);
        checks++; if (!ok) begin errors++; $display("FAIL frame_done_timeout: got no frame_done want pulse"); end
        repeat (2) @(negedge clk);
        checks++; if (capq.size() != 3) begin errors++; $display("FAIL frame_count: got %0d want 3", capq.size()); end
        for (int i = 0; i < 3; i++) begin
            got = (i < capq.size()) ? capq[i] : 24'hxxxxxx;
            checks++; if (got !== exp_px[i]) begin errors++; $display("FAIL frame_px%0d: got %h want %h", i, got, exp_px[i]); end
        end
        checks++; if (fd_high != 1) begin errors++; $display("FAIL frame_done_width: got %0d want 1", fd_high); end
        checks++; if (swap_pend !== 1'b0) begin errors++; $display("FAIL frame_pend_clear: got %b want 0", swap_pend); end
    endtask

    task automatic test_timeout();
        bit          ok;
        logic [23:0] got;
        logic [23:0] exp_px [3];
        exp_px = '{24'hAAABAC, 24'hADAEAF, 24'hB0B1B2};
        for (int i = 0; i < 4; i++) send_byte(1, 8'(8'h11 + i));
        repeat (45) @(posedge clk);
        #1;
        for (int i = 0; i < 9; i++) send_byte(1, 8'(8'hAA + i));
        checks++; if (swap_pend !== 1'b1) begin errors++; $display("FAIL timeout_pend_set: got %b want 1", swap_pend); end
        wait_swap(1, ok);
        checks++; if (!ok) begin errors++; $display("FAIL timeout_swap_timeout: got no swap want swap"); end
        capq.delete(); fd_high = 0;
        wait_fd(1, ok);
        repeat (2) @(negedge clk);
        checks++; if (capq.size() != 3) begin errors++; $display("FAIL timeout_count: got %0d want 3", capq.size()); end
        for (int i = 0; i < 3; i++) begin
            got = (i < capq.size()) ? capq[i] : 24'hxxxxxx;
            checks++; if (got !== exp_px[i]) begin errors++; $display("FAIL timeout_px%0d: got %h want %h", i, got, exp_px[i]); end
        end
    endtask

    task automatic test_drop_pending();
        bit          ok;
        logic [23:0] got;
        logic [23:0] exp_px [3];
        exp_px = '{24'hC1C2C3, 24'hC4C5C6, 24'hC7C8C9};
        wait_valid(ok);
        checks++; if (!ok) begin errors++; $display("FAIL drop_sync_timeout: got no px_valid want px_valid"); end
        for (int i = 0; i < 9; i++) send_byte(1, 8'(8'hC1 + i));
        checks++; if (swap_pend !== 1'b1) begin errors++; $display("FAIL drop_pend_set: got %b want 1", swap_pend); end
        for (int i = 0; i < 9; i++) send_byte(1, 8'(8'hD1 + i));
        wait_swap(1, ok);
        capq.delete(); fd_high = 0;
        wait_fd(1, ok);
        repeat (2) @(negedge clk);
        checks++; if (capq.size() != 3) begin errors++; $display("FAIL drop_count: got %0d want 3", capq.size()); end
        for (int i = 0; i < 3; i++) begin
            got = (i < capq.size()) ? capq[i] : 24'hxxxxxx;
            checks++; if (got !== exp_px[i]) begin errors++; $display("FAIL drop_px%0d: got %h want %h", i, got, exp_px[i]); end
        end
        checks++; if (swap_pend !== 1'b0) begin errors++; $display("FAIL drop_no_pend: got %b want 0", swap_pend); end
    endtask

    task automatic test_brightness();
        bit          ok;
        logic [23:0] got;
        logic [7:0]  bytes [6];
        logic [23:0] exp_px [2];
        bytes  = '{8'hFF, 8'h80, 8'h04, 8'h10, 8'h07, 8'hFE};
        exp_px = '{24'h3F2001, 24'h04013F};
        for (int i = 0; i < 6; i++) send_byte(2, bytes[i]);
        checks++; if (swap_pend2 !== 1'b1) begin errors++; $display("FAIL bright_pend_set: got %b want 1", swap_pend2); end
        wait_swap(2, ok);
        capq2.delete(); fd_high2 = 0;
        wait_fd(2, ok);
        checks++; if (!ok) begin errors++; $display("FAIL bright_done_timeout: got no frame_done want pulse"); end
        repeat (2) @(negedge clk);
        checks++; if (capq2.size() != 2) begin errors++; $display("FAIL bright_count: got %0d want 2", capq2.size()); end
        for (int i = 0; i < 2; i++) begin
            got = (i < capq2.size()) ? capq2[i] : 24'hxxxxxx;
            checks++; if (got !== exp_px[i]) begin errors++; $display("FAIL bright_px%0d: got %h want %h", i, got, exp_px[i]); end
        end
    endtask

    task automatic test_reset_mid_ack();
        bit ok;
        int n;
        wait_valid(ok);
        checks++; if (!ok) begin errors++; $display("FAIL rst_ack_sync_timeout: got no px_valid want px_valid"); end
        resetn = 1'b0;
        @(posedge clk); #1;
        checks++; if (px_valid !== 1'b0) begin errors++; $display("FAIL rst_ack_valid: got %b want 0", px_valid); end
        checks++; if ({px_r, px_g, px_b} !== 24'h0) begin errors++; $display("FAIL rst_ack_rgb: got %h want 000000", {px_r, px_g, px_b}); end
        @(posedge clk); #1;
        resetn = 1'b1;
        n = 0;
        for (int i = 1; i <= 60; i++) begin
            @(posedge clk); #1;
            if (px_valid === 1'b1) begin n = i; break; end
        end
        checks++; if (n != 17) begin errors++; $display("FAIL rst_first_valid_latency: got %0d want 17", n); end
    endtask

    task automatic test_hold();
        bit          ok;
        logic [23:0] got;
        logic [23:0] exp_px [3];
        exp_px = '{24'hE1E2E3, 24'hE4E5E6, 24'hE7E8E9};
        for (int i = 0; i < 9; i++) send_byte(1, 8'(8'hE1 + i));
        wait_swap(1, ok);
        checks++; if (!ok) begin errors++; $display("FAIL hold_swap_timeout: got no swap want swap"); end
        busy_hold = 1'b1;
        capq.delete(); fd_high = 0;
        wait_valid(ok);
        checks++; if (!ok) begin errors++; $display("FAIL hold_valid_timeout: got no px_valid want px_valid"); end
        for (int i = 0; i < 50; i++) begin
            @(negedge clk);
            checks++;
            if (px_valid !== 1'b1 || {px_r, px_g, px_b} !== 24'hE1E2E3) begin
                errors++;
                $display("FAIL hold_stable_c%0d: got valid=%b rgb=%h want valid=1 rgb=e1e2e3", i, px_valid, {px_r, px_g, px_b});
            end
        end
        busy_hold = 1'b0;
        wait_fd(1, ok);
        repeat (2) @(negedge clk);
        checks++; if (capq.size() != 3) begin errors++; $display("FAIL hold_count: got %0d want 3", capq.size()); end
        for (int i = 0; i < 3; i++) begin
            got = (i < capq.size()) ? capq[i] : 24'hxxxxxx;
            checks++; if (got !== exp_px[i]) begin errors++; $display("FAIL hold_px%0d: got %h want %h", i, got, exp_px[i]); end
        end
    endtask

    initial begin
        test_reset();
        test_frame();
        test_timeout();
        test_drop_pending();
        test_brightness();
        test_reset_mid_ack();
        test_hold();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: got no completion want completion");
        $fatal(1, "watchdog expired");
    end

endmodule
